// File: rtl/sr_bank_driver.sv
// Initiator for a bank of set/reset flops: accepts a masked target, pulses only the
// bits that differ from q, waits for the flops to settle, then reads q back and reports errors.
module sr_bank_driver #(
   parameter int N             = 8,
   parameter int PULSE_CYCLES  = 2,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [N-1:0] req_target,
   input  logic [N-1:0] req_mask,
   input  logic [N-1:0] q_fb,
   output logic [N-1:0] s_out,
   output logic [N-1:0] r_out,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [N-1:0] err_bits
);

   localparam int MAX_CYCLES = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);
   localparam logic [CW-1:0] PULSE_LOAD  = CW'(PULSE_CYCLES - 1);
   localparam logic [CW-1:0] SETTLE_LOAD = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, PULSE, SETTLE, CHECK} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [N-1:0]  target;
   logic [N-1:0]  mask;
   logic [N-1:0]  chg;
   logic [N-1:0]  set_bits;
   logic [N-1:0]  clr_bits;
   logic [N-1:0]  mm;
   logic          accept;

   // Set and clear vectors are derived from one chg bit each, so they can never overlap.
   for (genvar gi = 0; gi < N; gi++) begin : g_bit
      assign chg[gi]      = req_mask[gi] & (req_target[gi] ^ q_fb[gi]);
      assign set_bits[gi] = chg[gi] & req_target[gi];
      assign clr_bits[gi] = chg[gi] & ~req_target[gi];
      assign mm[gi]       = mask[gi] & (target[gi] ^ q_fb[gi]);
   end

   assign accept = req_valid & req_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         target    <= '0;
         mask      <= '0;
         s_out     <= '0;
         r_out     <= '0;
         req_ready <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         err_bits  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  target    <= req_target;
                  mask      <= req_mask;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (|chg) begin
                     state <= PULSE;
                     cnt   <= PULSE_LOAD;
                     s_out <= set_bits;
                     r_out <= clr_bits;
                  end else begin
                     state <= CHECK;
                  end
               end else begin
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            PULSE: begin
               if (cnt == '0) begin
                  s_out <= '0;
                  r_out <= '0;
                  if (SETTLE_CYCLES > 0) begin
                     state <= SETTLE;
                     cnt   <= SETTLE_LOAD;
                  end else begin
                     state <= CHECK;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            SETTLE: begin
               if (cnt == '0) begin
                  state <= CHECK;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            CHECK: begin
               // Readback uses q as it stands at the closing edge of this cycle.
               state     <= IDLE;
               done      <= 1'b1;
               err       <= |mm;
               err_bits  <= mm;
               req_ready <= 1'b1;
               busy      <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sr_bank_driver.sv
// Directed bench for sr_bank_driver driving eight behavioural SR flops,
// with a stuck-at-0 fault injectable on bit 3.
module tb_sr_bank_driver;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [7:0] req_target = '0;
   logic [7:0] req_mask = '0;
   logic [7:0] q_int;
   logic [7:0] q_fb;
   logic [7:0] s_out;
   logic [7:0] r_out;
   logic       busy;
   logic       done;
   logic       err;
   logic [7:0] err_bits;
   logic       stuck3 = 1'b0;

   int n_checks  = 0;
   int n_pass    = 0;
   int done_cnt  = 0;
   int excl_viol = 0;
   int dc0;

   always #5 clk = ~clk;

   sr_bank_driver #(.N(8), .PULSE_CYCLES(2), .SETTLE_CYCLES(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_target(req_target),
      .req_mask  (req_mask),
      .q_fb      (q_fb),
      .s_out     (s_out),
      .r_out     (r_out),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .err_bits  (err_bits)
   );

   always @(posedge clk or negedge rst) begin
      if (!rst) q_int <= '0;
      else      q_int <= (q_int | s_out) & ~r_out;
   end
   assign q_fb = q_int & ~(stuck3 ? 8'h08 : 8'h00);

   always @(negedge clk) begin
      if (done) done_cnt++;
      if ((s_out & r_out) != 8'h00) excl_viol++;
      assert ((s_out & r_out) == 8'h00);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_req(input string tag, input logic [7:0] tgt, input logic [7:0] msk,
                          input logic [7:0] es, input logic [7:0] er, input logic pulse,
                          input logic poke, input logic ee, input logic [7:0] eb,
                          input logic [7:0] eq);
      req_valid  = 1'b1;
      req_target = tgt;
      req_mask   = msk;
      tick();
      req_valid = 1'b0;
      if (poke) begin
         req_valid  = 1'b1;
         req_target = 8'h00;
      end
      if (pulse) begin
         for (int c = 0; c < 2; c++) begin
            check({tag, "_s"}, s_out, es);
            check({tag, "_r"}, r_out, er);
            check({tag, "_busy"}, busy, 1);
            tick();
         end
         check({tag, "_settle_sr"}, {s_out, r_out}, 0);
         check({tag, "_settle_done"}, done, 0);
         req_valid = 1'b0;
         tick();
         check({tag, "_chk_done"}, done, 0);
         check({tag, "_chk_busy"}, busy, 1);
         tick();
      end else begin
         check({tag, "_sr"}, {s_out, r_out}, 0);
         check({tag, "_chk_done"}, done, 0);
         check({tag, "_chk_busy"}, busy, 1);
         tick();
      end
      check({tag, "_done"}, done, 1);
      check({tag, "_err"}, err, ee);
      check({tag, "_err_bits"}, err_bits, eb);
      check({tag, "_ready"}, req_ready, 1);
      check({tag, "_idle"}, busy, 0);
      check({tag, "_q"}, q_fb, eq);
      $display("txn %s: target=0x%02h mask=0x%02h err=%0d err_bits=0x%02h q=0x%02h",
               tag, tgt, msk, err, err_bits, q_fb);
      tick();
      check({tag, "_done_1cyc"}, done, 0);
   endtask

   initial begin
      repeat (3) tick();
      check("rst_sr", {s_out, r_out}, 0);
      check("rst_flags", {req_ready, busy, done, err}, 0);
      check("rst_err_bits", err_bits, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rdy_pre_edge", req_ready, 0);
      tick();
      check("rdy_post_edge", req_ready, 1);
      check("busy_post_rst", busy, 0);

      run_req("set",   8'hA5, 8'hFF, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'hA5);
      run_req("mclr",  8'h0F, 8'hF0, 8'h00, 8'hA0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h05);
      run_req("nochg", 8'h05, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h05);
      run_req("clr",   8'h00, 8'hFF, 8'h00, 8'h05, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      stuck3 = 1'b1;
      run_req("fault", 8'h08, 8'hFF, 8'h08, 8'h00, 1'b1, 1'b0, 1'b1, 8'h08, 8'h00);
      repeat (3) tick();
      check("fault_err_held", err, 1);
      check("fault_bits_held", err_bits, 8'h08);
      check("fault_no_done", done, 0);

      dc0        = done_cnt;
      req_valid  = 1'b1;
      req_target = 8'h3C;
      req_mask   = 8'hFF;
      tick();
      req_valid = 1'b0;
      check("abort_s", s_out, 8'h3C);
      #2;
      rst = 1'b0;
      #1;
      check("abort_s_drop", s_out, 0);
      check("abort_flags", {req_ready, busy}, 0);
      $display("txn abort: rst asserted mid-pulse, s_out=0x%02h", s_out);
      stuck3 = 1'b0;
      repeat (2) tick();
      @(negedge clk);
      rst = 1'b1;
      tick();
      check("abort_no_done", done_cnt, dc0);
      check("abort_ready", req_ready, 1);
      check("abort_err_clr", err, 0);
      check("abort_q_clr", q_fb, 0);

      dc0 = done_cnt;
      run_req("poke",  8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'hFF);
      repeat (3) tick();
      check("poke_one_done", done_cnt, dc0 + 1);
      check("poke_idle", busy, 0);
      check("poke_q", q_fb, 8'hFF);
      check("excl", excl_viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
